cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single backing-memory port between the icache refill path and the dcache refill/writeback path of the Riscv141 core.
- Accepts one line request at a time from either cache and issues it to memory as a burst of BEATS data words.
- Read beats are routed back to the requesting cache; write beats are streamed from the dcache.
- Sits between the cache controllers and the memory model/DRAM interface; the core's `stall` input is derived from its busy state.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, width of one data beat in bits.
- BEATS, 4, beats per line burst; power of two, at least 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- ic_req_valid  input  1  icache line-read request.
- ic_req_ready  output  1  icache request accepted this cycle.
- ic_req_addr  input  ADDR_W  icache request byte address.
- ic_resp_valid  output  1  read beat for icache.
- ic_resp_data  output  DATA_W  read beat data.
- ic_resp_last  output  1  final beat of the icache burst.
- dc_req_valid  input  1  dcache line request.
- dc_req_ready  output  1  dcache request accepted this cycle.
- dc_req_rw  input  1  0 = line read, 1 = line write.
- dc_req_addr  input  ADDR_W  dcache request byte address.
- dc_wdata_valid  input  1  write beat valid.
- dc_wdata_ready  output  1  write beat accepted.
- dc_wdata  input  DATA_W  write beat data.
- dc_resp_valid  output  1  read beat for dcache.
- dc_resp_data  output  DATA_W  read beat data.
- dc_resp_last  output  1  final beat of the dcache burst.
- mem_req_valid  output  1  burst command valid.
- mem_req_ready  input  1  memory accepts command.
- mem_req_rw  output  1  0 = read, 1 = write.
- mem_req_addr  output  ADDR_W  line-aligned burst address.
- mem_wdata_valid  output  1  write beat to memory.
- mem_wdata_ready  input  1  memory accepts write beat.
- mem_wdata  output  DATA_W  write beat data.
- mem_resp_valid  input  1  read beat from memory.
- mem_resp_data  input  DATA_W  read beat data.
- busy  output  1  state is not IDLE.
- grant  output  1  owner of the current or last burst: 0 = icache, 1 = dcache.
- proto_err  output  1  sticky flag: mem_resp_valid seen outside RDATA.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; beat counter = 0; proto_err = 0; grant = 0.
  - Every output is 0 in the cycle after reset.
  - Reset asserted mid-burst aborts the burst. The memory side is reset in the same cycle.
- FSM states: IDLE, ISSUE, WDATA, RDATA.
- IDLE:
  - Winner is chosen combinationally from the pending valids (see the arbitration rule).
  - Only the winner's req_ready is driven high.
  - On handshake: latch addr with the low log2(BEATS*DATA_W/8) bits forced to 0, latch rw (icache is always 0), set grant, go to ISSUE.
  - The transfer takes 1 cycle; no request is accepted outside IDLE.
- ISSUE:
  - mem_req_valid = 1; mem_req_addr and mem_req_rw come from the latches and stay stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready: counter <= 0; go to WDATA if rw=1, else RDATA.
- WDATA:
  - mem_wdata_valid = dc_wdata_valid; dc_wdata_ready = mem_wdata_ready; mem_wdata = dc_wdata (combinational pass-through).
  - Each cycle with both valid and ready increments the counter.
  - The transfer with counter == BEATS-1 returns the FSM to IDLE.
  - Writes produce no response beats.
- RDATA:
  - Each mem_resp_valid is forwarded in the same cycle to the owner: *_resp_valid = 1, *_resp_data = mem_resp_data.
  - The non-owner's resp_valid stays 0.
  - *_resp_last = 1 when counter == BEATS-1; the FSM then returns to IDLE.
  - Caches cannot backpressure responses.
- mem_resp_valid in any state other than RDATA is dropped and sets proto_err; only reset clears proto_err.
- Minimum turnaround: the cycle after a burst ends is IDLE, so a new request is accepted 1 cycle after the last beat.
- Counter width is log2(BEATS), minimum 1 bit; it wraps to 0 at burst end.
- Arbitration (default, fixed priority): if both request in IDLE, the dcache wins.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register (reset value 1 = dcache) records the owner of the most recent accepted request.
  - On a simultaneous request, the requester that is not last_grant wins; a lone request always wins.
- Undefined:
  - Fixed priority, dcache always wins ties; no last_grant register.

Test Plan:
- icache read, ic_req_addr=0x1004, BEATS=4 -> mem_req_addr=0x1000, rw=0; memory beats 0xA0..0xA3 appear on ic_resp_data in the same cycles; ic_resp_last only on 0xA3; dc_resp_valid stays 0; ic_req_ready is accepted again 1 cycle later.
- dcache write to 0x2000 with mem_wdata_ready toggling 1,0,1,0 -> exactly 4 beats transferred in order, no *_resp_valid, FSM back in IDLE after the 4th transfer.
- Both valid every IDLE cycle for 4 bursts -> without the macro grant = 1,1,1,1; with ARB_ROUND_ROBIN_EN grant = 0,1,0,1.
- mem_req_ready held 0 for 10 cycles in ISSUE -> mem_req_valid = 1 and mem_req_addr unchanged throughout; busy = 1.
- reset driven 0 during beat 2 of an icache read -> next cycle all outputs 0, state IDLE; a following dcache read completes normally.
- mem_resp_valid pulsed in IDLE -> proto_err = 1 and stays 1, no resp_valid forwarded; cleared only by reset.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one burst memory port between icache line refills and dcache refills/writebacks.
// Optional macro ARB_ROUND_ROBIN_EN alternates the winner on simultaneous requests; otherwise the dcache wins ties.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    // icache request / response
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_last,
    // dcache request / write data / response
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_last,
    // backing memory
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    // status
    output logic              busy,
    output logic              grant,
    output logic              proto_err
);

    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_BYTES = BEATS * DATA_W / 8;
    localparam int OFF_W      = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic              r_grant;
    logic              r_proto_err;
    logic              w_pick_dc;
    logic              w_pick_ic;
    logic              w_accept;
    logic              w_cnt_last;

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1; a valid
    // source holds its payload until then. Response beats have no ready and cannot stall.
`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    assign w_pick_dc = dc_req_valid && (!ic_req_valid || !r_last_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_pick_dc;
        end
    end
`else
    assign w_pick_dc = dc_req_valid;
`endif

    assign w_pick_ic  = ic_req_valid && !w_pick_dc;
    assign w_accept   = (r_state == S_IDLE) && (ic_req_valid || dc_req_valid);
    assign w_cnt_last = (r_cnt == LAST_CNT);
    assign w_cnt_inc  = w_cnt_last ? '0 : r_cnt + CNT_W'(1);

    assign busy      = (r_state != S_IDLE);
    assign grant     = r_grant;
    assign proto_err = r_proto_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        ic_resp_data    = '0;
        ic_resp_last    = 1'b0;
        dc_resp_valid   = 1'b0;
        dc_resp_data    = '0;
        dc_resp_last    = 1'b0;
        dc_wdata_ready  = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        case (r_state)
            S_IDLE: begin
                ic_req_ready = w_pick_ic;
                dc_req_ready = w_pick_dc;
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = r_rw;
                mem_req_addr  = r_addr;
                if (mem_req_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rw ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                dc_wdata_ready  = mem_wdata_ready;
                mem_wdata       = dc_wdata;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                if (mem_resp_valid) begin
                    // Only the burst owner sees the beat; the other cache's valid stays low.
                    if (r_grant) begin
                        dc_resp_valid = 1'b1;
                        dc_resp_data  = mem_resp_data;
                        dc_resp_last  = w_cnt_last;
                    end else begin
                        ic_resp_valid = 1'b1;
                        ic_resp_data  = mem_resp_data;
                        ic_resp_last  = w_cnt_last;
                    end
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_grant     <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_proto_err <= r_proto_err | (mem_resp_valid && (r_state != S_RDATA));
            if (w_accept) begin
                // Bursts always start on a line boundary; the icache only ever reads.
                r_addr  <= (w_pick_dc ? dc_req_addr : ic_req_addr) & ADDR_MASK;
                r_rw    <= w_pick_dc & dc_req_rw;
                r_grant <= w_pick_dc;
            end
        end
    end

endmodule
